// File: rtl/sigmoid_grad.sv
// sigmoid_grad: FP16 backward pass of the sigmoid activation, dx = grad * y * (1 - y).
// One shared FP16 multiplier is time-multiplexed across two states; (1 - y) is
// formed in fixed point Q1.FRAC_W and renormalised back to FP16.
// Optional build macro SIGMOID_GRAD_RNE_EN: round-to-nearest-even in the (1 - y)
// normaliser and the multiplier. Without it every stage truncates toward zero.
module sigmoid_grad #(
  parameter int FRAC_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] y_in,
  input  logic [15:0] grad_in,
  output logic [15:0] dx_out,
  output logic        busy,
  output logic        done,
  output logic        sat
);

  typedef enum logic [2:0] {IDLE, ONEM, MUL1, MUL2, FIN} state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0] r_y;
  logic [15:0] r_grad;
  logic [15:0] r_om;
  logic [15:0] r_t;
  logic [15:0] r_res;
  logic        r_resSat;
  logic        r_ySpecial;

  logic              w_yZero;
  logic              w_yOne;
  logic [4:0]        w_shift;
  logic [FRAC_W:0]   w_yFix;
  logic [FRAC_W:0]   w_omFix;
  logic [FRAC_W:0]   w_omAlign;
  logic [4:0]        w_lz;
  logic [9:0]        w_omMant;
  logic [4:0]        w_omExp;
  logic [15:0]       w_om;

  logic [15:0]        w_ma;
  logic [15:0]        w_mb;
  logic [21:0]        w_prod;
  logic signed [6:0]  w_mExp;
  logic [9:0]         w_mMant;
  logic [15:0]        w_mulRes;
  logic               w_mulSat;
  logic               w_unused;

`ifdef SIGMOID_GRAD_RNE_EN
  logic        w_omGuard;
  logic        w_omSticky;
  logic [10:0] w_omRound;
  logic        w_mGuard;
  logic        w_mSticky;
  logic [10:0] w_mRound;
`endif

  // Next-state logic: only IDLE looks at start, so pulses while busy are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ONEM;
      ONEM:    w_next = MUL1;
      MUL1:    w_next = MUL2;
      MUL2:    w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // (1 - y) in fixed point: align y, subtract from 1.0, renormalise via leading-zero count.
  always_comb begin
    w_yZero = r_y[15] | (r_y[14:10] == 5'd0);
    w_yOne  = (r_y[14:10] >= 5'd15);
    w_shift = 5'd15 - r_y[14:10];
    w_yFix  = {1'b1, r_y[9:0], {(FRAC_W-10){1'b0}}} >> w_shift;
    w_omFix = {1'b1, {FRAC_W{1'b0}}} - w_yFix;
    w_lz    = 5'd0;
    for (int i = 0; i <= FRAC_W; i++) begin
      if (w_omFix[i]) w_lz = 5'(FRAC_W - i);
    end
    w_omAlign = w_omFix << w_lz;
    w_omMant  = w_omAlign[FRAC_W-1 -: 10];
    w_omExp   = 5'd15 - w_lz;
`ifdef SIGMOID_GRAD_RNE_EN
    w_omGuard  = w_omAlign[FRAC_W-11];
    w_omSticky = |w_omAlign[FRAC_W-12:0];
    w_omRound  = {1'b0, w_omMant};
    if (w_omGuard & (w_omSticky | w_omMant[0])) w_omRound = w_omRound + 11'd1;
    if (w_omRound[10]) begin
      w_omMant = 10'd0;
      w_omExp  = w_omExp + 5'd1;
    end else begin
      w_omMant = w_omRound[9:0];
    end
`endif
    w_om = {1'b0, w_omExp, w_omMant};
  end

  // Shared FP16 multiplier: y*om in MUL1, t*grad in MUL2; flush-to-zero, saturate on overflow.
  always_comb begin
    w_ma     = (r_state == MUL1) ? r_y  : r_t;
    w_mb     = (r_state == MUL1) ? r_om : r_grad;
    w_prod   = {1'b1, w_ma[9:0]} * {1'b1, w_mb[9:0]};
    w_mExp   = $signed({2'b00, w_ma[14:10]}) + $signed({2'b00, w_mb[14:10]}) - 7'sd15;
    w_mulSat = 1'b0;
    if (w_prod[21]) begin
      w_mExp  = w_mExp + 7'sd1;
      w_mMant = w_prod[20:11];
    end else begin
      w_mMant = w_prod[19:10];
    end
`ifdef SIGMOID_GRAD_RNE_EN
    w_mGuard  = w_prod[21] ? w_prod[10] : w_prod[9];
    w_mSticky = w_prod[21] ? (|w_prod[9:0]) : (|w_prod[8:0]);
    w_mRound  = {1'b0, w_mMant};
    if (w_mGuard & (w_mSticky | w_mMant[0])) w_mRound = w_mRound + 11'd1;
    if (w_mRound[10]) begin
      w_mMant = 10'd0;
      w_mExp  = w_mExp + 7'sd1;
    end else begin
      w_mMant = w_mRound[9:0];
    end
`endif
    if ((w_ma[14:10] == 5'd0) || (w_mb[14:10] == 5'd0) || (w_mExp <= 7'sd0)) begin
      w_mulRes = {w_ma[15] ^ w_mb[15], 15'd0};
    end else if (w_mExp >= 7'sd31) begin
      w_mulRes = {w_ma[15] ^ w_mb[15], 15'h7BFF};
      w_mulSat = 1'b1;
    end else begin
      w_mulRes = {w_ma[15] ^ w_mb[15], w_mExp[4:0], w_mMant};
    end
  end

`ifdef SIGMOID_GRAD_RNE_EN
  assign w_unused = w_omAlign[FRAC_W];
`else
  assign w_unused = ^{w_omAlign[FRAC_W], w_omAlign[FRAC_W-11:0], w_prod[9:0]};
`endif

  // Datapath and handshake registers, stepped by the FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y        <= 16'h0000;
      r_grad     <= 16'h0000;
      r_om       <= 16'h0000;
      r_t        <= 16'h0000;
      r_res      <= 16'h0000;
      r_resSat   <= 1'b0;
      r_ySpecial <= 1'b0;
      dx_out     <= 16'h0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_y    <= y_in;
            r_grad <= grad_in;
            busy   <= 1'b1;
          end
        end
        ONEM: begin
          r_om       <= w_om;
          r_ySpecial <= w_yZero | w_yOne;
        end
        MUL1: r_t <= w_mulRes;
        MUL2: begin
          if (r_ySpecial) begin
            r_res    <= 16'h0000;
            r_resSat <= 1'b0;
          end else if (r_grad[14:10] == 5'h1F) begin
            r_res    <= {r_grad[15], 15'h7BFF};
            r_resSat <= 1'b1;
          end else begin
            r_res    <= w_mulRes;
            r_resSat <= w_mulSat;
          end
        end
        FIN: begin
          dx_out <= r_res;
          sat    <= r_resSat;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_grad.sv
// tb_sigmoid_grad: directed checks of sigmoid_grad with hand-computed FP16 results.
module tb_sigmoid_grad;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] yIn;
  logic [15:0] gradIn;
  logic [15:0] dxOut;
  logic        busyOut;
  logic        doneOut;
  logic        satOut;

  int checkCount = 0;
  int errorCount = 0;
  int lat;
  int busyCycles;
  int doneCount;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  sigmoid_grad dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .y_in    (yIn),
    .grad_in (gradIn),
    .dx_out  (dxOut),
    .busy    (busyOut),
    .done    (doneOut),
    .sat     (satOut)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle, then waits (bounded) for done; lat counts edges after the start edge.
  task automatic applyStimulus(input logic [15:0] y, input logic [15:0] g);
    @(negedge clk);
    yIn    = y;
    gradIn = g;
    start  = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    lat        = 0;
    busyCycles = 0;
    while (!doneOut && lat < 12) begin
      if (busyOut) busyCycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runCase(input string tag, input logic [15:0] y, input logic [15:0] g,
                         input logic [15:0] expDx, input logic expSat);
    applyStimulus(y, g);
    checkOutput({tag, "_latency"}, lat, 4);
    checkOutput({tag, "_dx"}, dxOut, expDx);
    checkOutput({tag, "_sat"}, satOut, expSat);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, doneOut, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    yIn    = 16'h0000;
    gradIn = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_dx", dxOut, 16'h0000);
    checkOutput("reset_busy", busyOut, 1'b0);
    checkOutput("reset_done", doneOut, 1'b0);
    checkOutput("reset_sat", satOut, 1'b0);

    // 0.5 * 0.5 * 1.0 = 0.25, plus busy duration.
    runCase("half", 16'h3800, 16'h3C00, 16'h3400, 1'b0);
    checkOutput("half_busyCycles", busyCycles, 4);

    // 0.75 * 0.25 = 0.1875 ; 0.25 * -2.0 = -0.5
    runCase("threeQuarter", 16'h3A00, 16'h3C00, 16'h3200, 1'b0);
    runCase("negGrad", 16'h3800, 16'hC000, 16'hB800, 1'b0);

    // y zero, y one and negative y all give +0 regardless of grad.
    runCase("yZero", 16'h0000, 16'h4000, 16'h0000, 1'b0);
    runCase("yOne", 16'h3C00, 16'h4000, 16'h0000, 1'b0);
    runCase("yNeg", 16'hB800, 16'h4000, 16'h0000, 1'b0);

    // Infinite upstream gradient saturates with grad sign.
    runCase("posInf", 16'h3800, 16'h7C00, 16'h7BFF, 1'b1);

    // Start pulse during MUL1 must be ignored: exactly one done, first operands win.
    @(negedge clk);
    yIn    = 16'h3A00;
    gradIn = 16'h3C00;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    yIn    = 16'h3800;
    gradIn = 16'hC000;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (doneOut) doneCount++;
      @(negedge clk);
    end
    checkOutput("ignoreStart_doneCount", doneCount, 1);
    checkOutput("ignoreStart_dx", dxOut, 16'h3200);

    runCase("negInf", 16'h3800, 16'hFC00, 16'hFBFF, 1'b1);

    // Reset while in MUL2 aborts: outputs cleared, no done afterwards.
    @(negedge clk);
    yIn    = 16'h3800;
    gradIn = 16'h3C00;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", busyOut, 1'b0);
    checkOutput("abort_dx", dxOut, 16'h0000);
    checkOutput("abort_sat", satOut, 1'b0);
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (doneOut) doneCount++;
      @(negedge clk);
    end
    checkOutput("abort_noDone", doneCount, 0);

    runCase("afterAbort", 16'h3800, 16'h3C00, 16'h3400, 1'b0);

    // y = 0x3555: om = 0xAAB000 in Q1.24 -> mantissa 0x155 with guard=1, sticky=0.
    // Truncating: om=0x3955, t = 1365*1365 = 0x1C6E39 -> 0x331B.
    // Round-to-nearest-even: om=0x3956, t = 1365*1366 = 0x1C738E -> 0x331D.
`ifdef SIGMOID_GRAD_RNE_EN
    runCase("third", 16'h3555, 16'h3C00, 16'h331D, 1'b0);
`else
    runCase("third", 16'h3555, 16'h3C00, 16'h331B, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
